pid_output_limiter64: RTL and testbench
=======================================

// Module: pid_output_limiter64
// PURPOSE
//  Downstream stage of the 64-bit time-multiplexed PID initial/step block.
//  Consumes the serial y stream, one IEEE-754 double per wind-turbine channel per frame.
//  Clamps each sample to [LIM_LO, LIM_HI] and tags it with its channel index.
//  Flags saturation and NaN per sample, and reports a per-frame saturation count to the actuator stage.
// PARAMETERS
//  N_CH    `N_WindTurbine          channels per frame (>=2)
//  CHW     $clog2(N_CH)            channel index width
//  LIM_HI  64'h3FF0000000000000    upper clamp (+1.0)
//  LIM_LO  64'hBFF0000000000000    lower clamp (-1.0); LIM_LO <= LIM_HI required
// PORTS
//  clk         in   1      system clock
//  rst         in   1      asynchronous reset, active-low
//  rst_user    in   1      synchronous clear, active-high (frame restart)
//  in_valid    in   1      sample strobe (PID done_sig); one beat per channel
//  in_data     in   64     PID output y (IEEE double)
//  out_valid   out  1      clamped sample valid
//  out_data    out  64     clamped sample
//  out_ch      out  CHW    channel index of out_data
//  out_sat_hi  out  1      sample was > LIM_HI
//  out_sat_lo  out  1      sample was < LIM_LO
//  out_nan     out  1      sample was NaN (output forced to LIM_LO)
//  frame_done  out  1      1-cycle pulse coincident with out_valid of channel N_CH-1
//  sat_count   out  CHW+1  saturated+NaN samples in last completed frame
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs 0; channel counter 0; frame accumulator 0.
//  - rst_user=1: same clear on the next edge.
//    - Clears the pipeline: in-flight samples are dropped; out_valid=0 next cycle.
//    - rst_user dominates in_valid in the same cycle.
//  - Latency: fixed 2 cycles, in_valid -> out_valid. Stage 1 registers the compare results; stage 2 registers the mux and flags.
//  - No backpressure: in_valid may be high every cycle; gaps are allowed anywhere.
//  - The counter advances only on accepted beats.
//  - Channel counter: 0..N_CH-1, increments per in_valid beat, wraps to 0 after N_CH-1. out_ch carries the counter value captured at input.
//  - Ordering key for a double v:
//    - sign=0: key = {1'b1, v[62:0]}
//    - sign=1: key = ~v
//    - Keys are compared unsigned. -0.0 orders below +0.0; both pass unchanged inside limits.
//  - NaN: exp==11'h7FF and mant!=0. out_data=LIM_LO; out_nan=1; sat flags 0.
//  - Inf: ordinary value, clamped (+Inf -> LIM_HI with sat_hi).
//  - Clamp: key(v) > key(HI) -> HI, sat_hi; key(v) < key(LO) -> LO, sat_lo; else v unchanged (bit-exact).
//  - Value equal to a limit is not saturated.
//  - Flags/out_ch are valid only when out_valid=1; they hold their last value otherwise.
//  - Frame accumulator:
//    - Counts (sat_hi|sat_lo|nan) at stage 2.
//    - On the channel N_CH-1 beat, sat_count <= acc + this beat's flag and acc <= 0.
//    - sat_count holds until the next frame end.
//  - Reset mid-frame: the partial frame is discarded; sat_count keeps its previous value on rst_user; it is 0 on rst.
// STRUCTURE
//  - Shared package/global_parameter.v: N_WindTurbine, FP64_POS_ONE, FP64_NEG_ONE, FP64_EXP_MAX (11'h7FF).
//  - One sub-module: fp64_clamp_stage.
//    - 2-stage registered key/compare/mux for one sample, with flags.
//    - The top owns the channel counter, the valid pipe and the frame accumulator.
// TESTING
//  - Reset: hold rst=0 with in_valid toggling -> all outputs 0; release, first beat -> out_ch=0 after 2 cycles.
//  - Frame, N_CH=4, back-to-back:
//    - Input: 0.5 (3FE0...), 2.0 (4000...), -3.0 (C008...), 1.0.
//    - out_data = 3FE0..., 3FF0... with sat_hi, BFF0... with sat_lo, 3FF0... with no flag.
//    - frame_done on the 4th output; sat_count=2.
//  - Specials:
//    - 7FF8000000000000 -> BFF0..., out_nan.
//    - 7FF0000000000000 (+Inf) -> 3FF0..., sat_hi.
//    - 8000000000000000 (-0.0) -> unchanged, no flags.
//  - Gaps: in_valid pattern 1,0,0,1,1,0,1 -> out_ch 0,1,2,3 at input+2; exactly one frame_done; wrap to 0 on the next beat.
//  - rst_user mid-frame: after 2 beats -> no out_valid for the in-flight beats; the next beat gets out_ch=0; sat_count unchanged.
//  - Simultaneous rst_user & in_valid -> beat dropped, counter=0; the following beat is channel 0.

Source files
------------

// File: rtl/pid_output_limiter64_pkg.sv
// Shared constants and helpers for the PID output limiter: channel count,
// IEEE-754 double constants and the sign-magnitude ordering key.
package pid_output_limiter64_pkg;

  localparam int          N_WINDTURBINE = 4;
  localparam logic [63:0] FP64_POS_ONE  = 64'h3FF0000000000000;
  localparam logic [63:0] FP64_NEG_ONE  = 64'hBFF0000000000000;
  localparam logic [10:0] FP64_EXP_MAX  = 11'h7FF;

  // Per-sample outcome of the clamp.
  typedef struct packed {
    logic sat_hi;
    logic sat_lo;
    logic nan;
  } clamp_flags_t;

  // Maps a double onto an unsigned key whose order matches numeric order
  // (with -0.0 just below +0.0). Positive values get the top bit set so
  // they sit above every negative value; negatives are inverted so larger
  // magnitudes give smaller keys.
  function automatic logic [63:0] fp64_key(input logic [63:0] v);
    logic [63:0] k;
    if (v[63]) begin
      k = ~v;
    end else begin
      k = {1'b1, v[62:0]};
    end
    return k;
  endfunction

  // NaN: all-ones exponent with a non-zero mantissa (Inf is not a NaN).
  function automatic logic fp64_is_nan(input logic [63:0] v);
    return (v[62:52] == FP64_EXP_MAX) && (v[51:0] != 52'd0);
  endfunction

endpackage

// File: rtl/pid_output_limiter64_fp64_clamp_stage.sv
// Two-stage clamp of one IEEE double: stage 1 registers the sample with its
// limit-compare results, stage 2 registers the selected output and flags.
module fp64_clamp_stage
  import pid_output_limiter64_pkg::*;
#(
  parameter logic [63:0] LIM_HI = FP64_POS_ONE,
  parameter logic [63:0] LIM_LO = FP64_NEG_ONE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         s1_en_i,
  input  logic         s2_en_i,
  input  logic [63:0]  data_i,
  output logic         s1_flag_o,
  output logic [63:0]  data_o,
  output clamp_flags_t flags_o
);

  localparam logic [63:0] KEY_HI = fp64_key(LIM_HI);
  localparam logic [63:0] KEY_LO = fp64_key(LIM_LO);

  logic [63:0]  key_s;
  logic         nan_s;
  clamp_flags_t flags1_d, flags1_q;
  logic [63:0]  data1_q;
  logic [63:0]  data2_d, data2_q;
  clamp_flags_t flags2_q;

  // Compare the incoming sample against both limits; NaN masks the sat flags.
  always_comb begin
    key_s           = fp64_key(data_i);
    nan_s           = fp64_is_nan(data_i);
    flags1_d        = '0;
    flags1_d.nan    = nan_s;
    flags1_d.sat_hi = ~nan_s && (key_s > KEY_HI);
    flags1_d.sat_lo = ~nan_s && (key_s < KEY_LO);
  end

  // Stage 1: hold the raw sample and its compare results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data1_q  <= 64'd0;
      flags1_q <= '0;
    end else if (clr_i) begin
      data1_q  <= 64'd0;
      flags1_q <= '0;
    end else if (s1_en_i) begin
      data1_q  <= data_i;
      flags1_q <= flags1_d;
    end else begin
      data1_q  <= data1_q;
      flags1_q <= flags1_q;
    end
  end

  // Select the clamped value; in-range samples pass through bit-exact.
  always_comb begin
    data2_d = data1_q;
    if (flags1_q.nan) begin
      data2_d = LIM_LO;
    end else if (flags1_q.sat_hi) begin
      data2_d = LIM_HI;
    end else if (flags1_q.sat_lo) begin
      data2_d = LIM_LO;
    end else begin
      data2_d = data1_q;
    end
  end

  // Stage 2: output value and flags, held between valid beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data2_q  <= 64'd0;
      flags2_q <= '0;
    end else if (clr_i) begin
      data2_q  <= 64'd0;
      flags2_q <= '0;
    end else if (s2_en_i) begin
      data2_q  <= data2_d;
      flags2_q <= flags1_q;
    end else begin
      data2_q  <= data2_q;
      flags2_q <= flags2_q;
    end
  end

  assign s1_flag_o = flags1_q.sat_hi | flags1_q.sat_lo | flags1_q.nan;
  assign data_o    = data2_q;
  assign flags_o   = flags2_q;

endmodule

// File: rtl/pid_output_limiter64.sv
// Output limiter for the time-multiplexed PID: clamps each channel's y to
// [LIM_LO, LIM_HI], tags it with its channel and counts saturations per frame.
module pid_output_limiter64
  import pid_output_limiter64_pkg::*;
#(
  parameter int          N_CH   = N_WINDTURBINE,
  parameter int          CHW    = $clog2(N_CH),
  parameter logic [63:0] LIM_HI = FP64_POS_ONE,
  parameter logic [63:0] LIM_LO = FP64_NEG_ONE
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rst_user,
  input  logic           in_valid,
  input  logic [63:0]    in_data,
  output logic           out_valid,
  output logic [63:0]    out_data,
  output logic [CHW-1:0] out_ch,
  output logic           out_sat_hi,
  output logic           out_sat_lo,
  output logic           out_nan,
  output logic           frame_done,
  output logic [CHW:0]   sat_count
);

  localparam logic [CHW-1:0] LAST_CH = CHW'(N_CH - 1);

  logic           accept_s;
  logic [CHW-1:0] ch_d, ch_q;
  logic           v1_q;
  logic [CHW-1:0] ch1_q;
  logic           out_valid_q;
  logic [CHW-1:0] out_ch_q;
  logic           frame_done_q;
  logic [CHW:0]   acc_d, acc_q;
  logic [CHW:0]   sat_count_d, sat_count_q;
  logic           s1_flag_s;
  logic [CHW:0]   s1_inc_s;
  logic           last_s;
  clamp_flags_t   flags_s;

  // rst_user wins over a beat presented in the same cycle.
  assign accept_s = in_valid & ~rst_user;

  fp64_clamp_stage #(
    .LIM_HI (LIM_HI),
    .LIM_LO (LIM_LO)
  ) u_clamp (
    .clk       (clk),
    .rst_n     (rst),
    .clr_i     (rst_user),
    .s1_en_i   (accept_s),
    .s2_en_i   (v1_q),
    .data_i    (in_data),
    .s1_flag_o (s1_flag_s),
    .data_o    (out_data),
    .flags_o   (flags_s)
  );

  // Next channel index: advance on accepted beats, wrap after the last channel.
  always_comb begin
    ch_d = ch_q;
    if (accept_s) begin
      if (ch_q == LAST_CH) begin
        ch_d = '0;
      end else begin
        ch_d = ch_q + 1'b1;
      end
    end else begin
      ch_d = ch_q;
    end
  end

  // Channel counter and the valid/channel pipeline alongside the clamp stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_q         <= '0;
      v1_q         <= 1'b0;
      ch1_q        <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      frame_done_q <= 1'b0;
    end else if (rst_user) begin
      ch_q         <= '0;
      v1_q         <= 1'b0;
      ch1_q        <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      ch_q         <= ch_d;
      v1_q         <= accept_s;
      ch1_q        <= accept_s ? ch_q : ch1_q;
      out_valid_q  <= v1_q;
      out_ch_q     <= v1_q ? ch1_q : out_ch_q;
      frame_done_q <= v1_q && (ch1_q == LAST_CH);
    end
  end

  assign last_s   = v1_q && (ch1_q == LAST_CH);
  assign s1_inc_s = {{CHW{1'b0}}, s1_flag_s};

  // Frame accumulator: add each stage-2 beat's flag, publish on the last channel.
  always_comb begin
    acc_d       = acc_q;
    sat_count_d = sat_count_q;
    if (last_s) begin
      sat_count_d = acc_q + s1_inc_s;
      acc_d       = '0;
    end else if (v1_q) begin
      acc_d       = acc_q + s1_inc_s;
    end else begin
      acc_d       = acc_q;
    end
  end

  // Accumulator and published count; a frame restart drops the partial count only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q       <= '0;
      sat_count_q <= '0;
    end else if (rst_user) begin
      acc_q       <= '0;
      sat_count_q <= sat_count_q;
    end else begin
      acc_q       <= acc_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;
  assign out_sat_hi = flags_s.sat_hi;
  assign out_sat_lo = flags_s.sat_lo;
  assign out_nan    = flags_s.nan;
  assign frame_done = frame_done_q;
  assign sat_count  = sat_count_q;

endmodule

// File: tb/tb_pid_output_limiter64.sv
// Directed bench for pid_output_limiter64 (N_CH = 4, limits +/-1.0).
module tb_pid_output_limiter64;

  localparam int N_CH = 4;
  localparam int CHW  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           rst_user;
  logic           in_valid;
  logic [63:0]    in_data;
  logic           out_valid;
  logic [63:0]    out_data;
  logic [CHW-1:0] out_ch;
  logic           out_sat_hi;
  logic           out_sat_lo;
  logic           out_nan;
  logic           frame_done;
  logic [CHW:0]   sat_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Vector table: drive (rst_user, in_valid, data) and expected output slot.
  logic        vr [16];
  logic        vv [16];
  logic [63:0] vd [16];
  logic        ev [16];
  logic [63:0] ed [16];
  logic [1:0]  ec [16];
  logic [2:0]  ef [16];
  logic        efd[16];
  int          nvec;

  pid_output_limiter64 #(.N_CH(N_CH)) dut (
    .clk        (clk),
    .rst        (rst),
    .rst_user   (rst_user),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .out_sat_hi (out_sat_hi),
    .out_sat_lo (out_sat_lo),
    .out_nan    (out_nan),
    .frame_done (frame_done),
    .sat_count  (sat_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_vec(input int idx, input logic r, input logic v, input logic [63:0] d,
                         input logic e_v, input logic [63:0] e_d, input logic [1:0] e_c,
                         input logic [2:0] e_f, input logic e_fd);
    vr[idx]  = r;
    vv[idx]  = v;
    vd[idx]  = d;
    ev[idx]  = e_v;
    ed[idx]  = e_d;
    ec[idx]  = e_c;
    ef[idx]  = e_f;
    efd[idx] = e_fd;
  endtask

  // Drive one vector per falling edge; the slot for vector i appears two cycles later.
  task automatic run_vecs(input string name);
    for (int i = 0; i < nvec + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check_eq($sformatf("%s[%0d].valid", name, i - 2), {63'd0, out_valid}, {63'd0, ev[i-2]});
        check_eq($sformatf("%s[%0d].frame_done", name, i - 2), {63'd0, frame_done}, {63'd0, efd[i-2]});
        if (ev[i-2]) begin
          check_eq($sformatf("%s[%0d].data", name, i - 2), out_data, ed[i-2]);
          check_eq($sformatf("%s[%0d].ch", name, i - 2), {62'd0, out_ch}, {62'd0, ec[i-2]});
          check_eq($sformatf("%s[%0d].flags", name, i - 2),
                   {61'd0, out_sat_hi, out_sat_lo, out_nan}, {61'd0, ef[i-2]});
        end
      end
      if (i < nvec) begin
        rst_user = vr[i];
        in_valid = vv[i];
        in_data  = vd[i];
      end else begin
        rst_user = 1'b0;
        in_valid = 1'b0;
        in_data  = 64'd0;
      end
    end
  endtask

  initial begin
    rst      = 1'b0;
    rst_user = 1'b0;
    in_valid = 1'b0;
    in_data  = 64'h4000000000000000;

    // Reset held with in_valid toggling: everything stays at zero.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
    end
    @(negedge clk);
    check_eq("rst.valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst.data", out_data, 64'd0);
    check_eq("rst.ch", {62'd0, out_ch}, 64'd0);
    check_eq("rst.flags", {61'd0, out_sat_hi, out_sat_lo, out_nan}, 64'd0);
    check_eq("rst.frame_done", {63'd0, frame_done}, 64'd0);
    check_eq("rst.sat_count", {61'd0, sat_count}, 64'd0);
    rst      = 1'b1;
    in_valid = 1'b0;

    // Back-to-back frame.
    nvec = 4;
    set_vec(0, 1'b0, 1'b1, 64'h3FE0000000000000, 1'b1, 64'h3FE0000000000000, 2'd0, 3'b000, 1'b0);
    set_vec(1, 1'b0, 1'b1, 64'h4000000000000000, 1'b1, 64'h3FF0000000000000, 2'd1, 3'b100, 1'b0);
    set_vec(2, 1'b0, 1'b1, 64'hC008000000000000, 1'b1, 64'hBFF0000000000000, 2'd2, 3'b010, 1'b0);
    set_vec(3, 1'b0, 1'b1, 64'h3FF0000000000000, 1'b1, 64'h3FF0000000000000, 2'd3, 3'b000, 1'b1);
    run_vecs("frame");
    check_eq("frame.sat_count", {61'd0, sat_count}, 64'd2);

    // Specials: NaN, +Inf, -0.0 and a value equal to the lower limit.
    nvec = 4;
    set_vec(0, 1'b0, 1'b1, 64'h7FF8000000000000, 1'b1, 64'hBFF0000000000000, 2'd0, 3'b001, 1'b0);
    set_vec(1, 1'b0, 1'b1, 64'h7FF0000000000000, 1'b1, 64'h3FF0000000000000, 2'd1, 3'b100, 1'b0);
    set_vec(2, 1'b0, 1'b1, 64'h8000000000000000, 1'b1, 64'h8000000000000000, 2'd2, 3'b000, 1'b0);
    set_vec(3, 1'b0, 1'b1, 64'hBFF0000000000000, 1'b1, 64'hBFF0000000000000, 2'd3, 3'b000, 1'b1);
    run_vecs("special");
    check_eq("special.sat_count", {61'd0, sat_count}, 64'd2);

    // Gaps 1,0,0,1,1,0,1 then one more beat that wraps to channel 0.
    nvec = 8;
    set_vec(0, 1'b0, 1'b1, 64'h3FD0000000000000, 1'b1, 64'h3FD0000000000000, 2'd0, 3'b000, 1'b0);
    set_vec(1, 1'b0, 1'b0, 64'h0,                1'b0, 64'h0,                2'd0, 3'b000, 1'b0);
    set_vec(2, 1'b0, 1'b0, 64'h0,                1'b0, 64'h0,                2'd0, 3'b000, 1'b0);
    set_vec(3, 1'b0, 1'b1, 64'hBFD0000000000000, 1'b1, 64'hBFD0000000000000, 2'd1, 3'b000, 1'b0);
    set_vec(4, 1'b0, 1'b1, 64'h4014000000000000, 1'b1, 64'h3FF0000000000000, 2'd2, 3'b100, 1'b0);
    set_vec(5, 1'b0, 1'b0, 64'h0,                1'b0, 64'h0,                2'd0, 3'b000, 1'b0);
    set_vec(6, 1'b0, 1'b1, 64'h0000000000000000, 1'b1, 64'h0000000000000000, 2'd3, 3'b000, 1'b1);
    set_vec(7, 1'b0, 1'b1, 64'h3FD0000000000000, 1'b1, 64'h3FD0000000000000, 2'd0, 3'b000, 1'b0);
    run_vecs("gaps");
    check_eq("gaps.sat_count", {61'd0, sat_count}, 64'd1);

    // rst_user mid-frame (channels 1,2 issued): the in-flight beat is dropped.
    nvec = 3;
    set_vec(0, 1'b0, 1'b1, 64'h4000000000000000, 1'b1, 64'h3FF0000000000000, 2'd1, 3'b100, 1'b0);
    set_vec(1, 1'b0, 1'b1, 64'h3FE0000000000000, 1'b0, 64'h0,                2'd0, 3'b000, 1'b0);
    set_vec(2, 1'b1, 1'b0, 64'h0,                1'b0, 64'h0,                2'd0, 3'b000, 1'b0);
    run_vecs("restart");
    check_eq("restart.sat_count", {61'd0, sat_count}, 64'd1);
    check_eq("restart.data_cleared", out_data, 64'd0);

    // Fresh frame after the restart: the discarded partial count must not leak in.
    nvec = 4;
    set_vec(0, 1'b0, 1'b1, 64'h3FE0000000000000, 1'b1, 64'h3FE0000000000000, 2'd0, 3'b000, 1'b0);
    set_vec(1, 1'b0, 1'b1, 64'hBFE0000000000000, 1'b1, 64'hBFE0000000000000, 2'd1, 3'b000, 1'b0);
    set_vec(2, 1'b0, 1'b1, 64'h3FF0000000000000, 1'b1, 64'h3FF0000000000000, 2'd2, 3'b000, 1'b0);
    set_vec(3, 1'b0, 1'b1, 64'hBFF0000000000000, 1'b1, 64'hBFF0000000000000, 2'd3, 3'b000, 1'b1);
    run_vecs("post_restart");
    check_eq("post_restart.sat_count", {61'd0, sat_count}, 64'd0);

    // rst_user and in_valid together: beat dropped, next beat is channel 0.
    nvec = 2;
    set_vec(0, 1'b1, 1'b1, 64'h4000000000000000, 1'b0, 64'h0,                2'd0, 3'b000, 1'b0);
    set_vec(1, 1'b0, 1'b1, 64'h4000000000000000, 1'b1, 64'h3FF0000000000000, 2'd0, 3'b100, 1'b0);
    run_vecs("simul");
    check_eq("simul.sat_count", {61'd0, sat_count}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
